// File: rtl/seq_det_sched_if.sv
// seq_det_sched_if: request, stream and detector signals of seq_det_sched
// Ports (signals):
//   req, frame_len, bit_valid, bit_in, abort   requester side into the scheduler
//   bit_ready, gnt                             per-requester handshake back
//   det_clr, det_en, det_bit / det_match       shared external 1011 detector
//   done, done_id, done_cnt, done_abort        frame-complete report
interface seq_det_sched_if #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]  req, bit_valid, bit_in, bit_ready, gnt;
    logic [LEN_W-1:0] frame_len;
    logic             abort, det_clr, det_en, det_bit, det_match;
    logic             done, done_abort;
    logic [IDW-1:0]   done_id;
    logic [CNT_W-1:0] done_cnt;
    modport master (
        output req, frame_len, bit_valid, bit_in, abort, det_match,
        input  bit_ready, gnt, det_clr, det_en, det_bit, done, done_id, done_cnt, done_abort
    );
    modport slave (
        input  req, frame_len, bit_valid, bit_in, abort, det_match,
        output bit_ready, gnt, det_clr, det_en, det_bit, done, done_id, done_cnt, done_abort
    );
endinterface

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one 1011 detector among NREQ bit streams
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_det_sched_if.slave (requests, stream handshake, detector control, done report)
module seq_det_sched #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    seq_det_sched_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [NREQ-1:0]  r_gnt;
    logic [IDW-1:0]   r_gid, r_ptr, w_win;
    logic [LEN_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort, w_found, w_xfer, w_last;

    assign w_xfer = (r_state == RUN) && bus.bit_valid[r_gid];
    assign w_last = w_xfer && (r_rem == LEN_W'(1));

    assign bus.gnt        = r_gnt;
    assign bus.bit_ready  = (r_state == RUN) ? r_gnt : '0;
    assign bus.det_clr    = (r_state == FLUSH);
    assign bus.det_en     = w_xfer;
    assign bus.det_bit    = w_xfer && bus.bit_in[r_gid];
    assign bus.done       = (r_state == DONE);
    assign bus.done_id    = (r_state == DONE) ? r_gid : '0;
    assign bus.done_cnt   = (r_state == DONE) ? r_cnt : '0;
    assign bus.done_abort = (r_state == DONE) && r_abort;

    // First requester at or after r_ptr, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = FLUSH;
            FLUSH:   w_next = (bus.frame_len == '0) ? DONE : RUN;
            RUN:     if (w_last || bus.abort) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_gnt <= NREQ'(1) << w_win;
                    r_gid <= w_win;
                    r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
                end
                FLUSH: begin
                    r_rem   <= bus.frame_len;
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                end
                RUN: begin
                    if (w_xfer) r_rem <= r_rem - LEN_W'(1);
                    // a transfer in the abort cycle still counts its match
                    if (w_xfer && bus.det_match && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
                    r_abort <= bus.abort;
                end
                DONE:    r_gnt <= '0;
                default: r_gnt <= '0;
            endcase
        end
    end
endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of stream requesters sharing one 1011 detector.
REQ-002 SHALL have parameter LEN_W, default 8, width of the frame length in bits.
REQ-003 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  in  NREQ  per-requester frame request, level.
REQ-007 SHALL have port frame_len  in  LEN_W  bits per frame of the winning requester; sampled in FLUSH.
REQ-008 SHALL have port bit_valid  in  NREQ  per-requester stream bit valid.
REQ-009 SHALL have port bit_in  in  NREQ  per-requester stream bit.
REQ-010 SHALL have port bit_ready  out  NREQ  per-requester ready; only the granted bit may be 1.
REQ-011 SHALL have port abort  in  1  terminate the current frame early.
REQ-012 SHALL have port gnt  out  NREQ  one-hot grant, registered.
REQ-013 SHALL have port det_clr  out  1  synchronous clear to the shared detector (returns it to its start state).
REQ-014 SHALL have port det_en  out  1  detector clock-enable; the detector advances only when det_en=1.
REQ-015 SHALL have port det_bit  out  1  bit presented to the detector.
REQ-016 SHALL have port det_match  in  1  detector Mealy match, valid in the same cycle as det_bit when det_en=1.
REQ-017 SHALL have port done  out  1  one-cycle frame-complete pulse.
REQ-018 SHALL have ports done_id  out  clog2(NREQ)  and done_cnt  out  CNT_W, granted index and match count; both valid while done=1.
REQ-019 SHALL have port done_abort  out  1  frame ended by abort, valid while done=1.

Function
REQ-020 SHALL implement the state machine IDLE -> FLUSH -> RUN -> DONE -> IDLE.
REQ-021 IDLE: when req!=0, SHALL pick the winner round-robin, register gnt, and enter FLUSH on the next edge.
REQ-022 Round-robin search SHALL start at (last granted index + 1) mod NREQ; after reset it SHALL start at index 0.
REQ-023 FLUSH (1 cycle): det_clr=1, remaining=frame_len, count=0; SHALL go to DONE if frame_len==0, else to RUN.
REQ-024 RUN: bit_ready[g]=1; a transfer occurs when bit_valid[g]&bit_ready[g]; in that cycle det_en=1, det_bit=bit_in[g], and remaining decrements.
REQ-025 det_en SHALL be 0 when no transfer occurs (valid gaps stall the detector); det_bit SHALL be 0 outside transfers.
REQ-026 count SHALL increment on det_match&det_en, and saturate at 2^CNT_W-1.
REQ-027 On the transfer that brings remaining to 0, the state machine SHALL enter DONE; that transfer's match SHALL be counted.
REQ-028 abort in RUN SHALL enter DONE next cycle with done_abort=1; a transfer in the same cycle still completes and counts.
REQ-029 abort outside RUN SHALL be ignored.
REQ-030 DONE (1 cycle): done=1 with done_id, done_cnt, done_abort; gnt held; gnt cleared on entry to IDLE.
REQ-031 Deassertion of req[g] during FLUSH or RUN SHALL be ignored; the frame runs to length or abort.
REQ-032 Minimum frame-to-frame gap is 1 IDLE cycle; gnt SHALL never have more than one bit set.
REQ-033 Overlapping patterns SHALL be counted as the detector reports them; no de-duplication.

Reset
REQ-034 rst_n=0 at any time, including mid-RUN, SHALL force IDLE, RR pointer 0, count 0, remaining 0, and all outputs 0; no done is issued for the aborted frame.

Verification
REQ-035 Single frame: req=0001, frame_len=7, bits 1,0,1,1,0,1,1 back-to-back -> gnt=0001 one cycle after req; done_cnt=2, done_id=0, done_abort=0.
REQ-036 Fairness: req=1111 held for 5 frames -> grant order 0,1,2,3,0.
REQ-037 Stalls: same 7 bits with valid gaps of 1-3 cycles -> det_en pulses exactly 7 times, done_cnt=2.
REQ-038 Edge lengths: frame_len=0 -> FLUSH then DONE, done_cnt=0; CNT_W=2 with 5 matches -> done_cnt=3.
REQ-039 Abort after 4 bits 1,0,1,1 -> done next cycle, done_abort=1, done_cnt=1.
REQ-040 Reset mid-RUN, then req=0010 -> no done for the first frame; all outputs 0 during reset; gnt=0010 afterwards, since the RR pointer is 0.
